// File: rtl/router_fsm.sv
// router_fsm: 1x3 router control FSM (address decode, load sequencing, full back-pressure, parity ordering)
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] empty_v, soft_v;

    // address 3 has no FIFO: treat it as never empty and never soft-reset
    assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    // state and captured destination address
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // next-state logic; soft reset of the selected FIFO overrides every transition
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    addr_d = data_in;
                    if (data_in != 2'b11)
                        state_d = empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY:    state_d = empty_v[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA:          state_d = fifo_full ? FIFO_FULL_STATE : (pkt_valid ? LOAD_DATA : LOAD_PARITY);
            FIFO_FULL_STATE:    state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    state_d = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_d = DECODE_ADDRESS;
        endcase
        if (state_q != DECODE_ADDRESS && soft_v[addr_q])
            state_d = DECODE_ADDRESS;
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = ld_state | laf_state | (state_q == LOAD_PARITY);
    assign busy          = !(detect_add | ld_state);
endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Control state machine for the 1x3 router. It decodes the header address and sequences the packet into the destination FIFO. It also handles FIFO-full back-pressure and orders parity load and parity check. Its outputs drive the input register block (strobes: lfd_state, ld_state, laf_state, full_state, rst_int_reg) and router_sync (detect_add, write_enb_reg), and report busy to the source.

Parameters:
none (three destinations and 2-bit address fixed by router topology)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source driving valid packet bytes
data_in  input  2  header address bits (byte[1:0]), sampled in DECODE_ADDRESS
parity_done  input  1  parity byte already written (from register block)
low_pkt_valid  input  1  pkt_valid fell while FIFO was full (from register block)
fifo_full  input  1  selected FIFO full (from router_sync)
fifo_empty_0..2  input  1 each  per-FIFO empty flags
soft_reset_0..2  input  1 each  per-FIFO read-timeout soft reset (from router_sync)
busy  output  1  source must hold data
detect_add  output  1  header decode cycle
lfd_state  output  1  load first (header) byte
ld_state  output  1  load payload byte
laf_state  output  1  load byte held during full
full_state  output  1  FIFO full wait
write_enb_reg  output  1  FIFO write enable request to router_sync
rst_int_reg  output  1  clear internal parity register/check

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY. Reset state is DECODE_ADDRESS.
- On resetn low, asynchronously force DECODE_ADDRESS and clear addr_q to 2'b00.
  - Output values in reset: detect_add=1; all other outputs 0.
- addr_q captures data_in on the clock edge where state==DECODE_ADDRESS and pkt_valid==1.
- Transitions. Priority: resetn > soft reset > listed rules.
  - DECODE_ADDRESS, pkt_valid=1, data_in in {0,1,2}, fifo_empty_[data_in]=1: go to LOAD_FIRST_DATA.
  - DECODE_ADDRESS, pkt_valid=1, data_in in {0,1,2}, fifo_empty_[data_in]=0: go to WAIT_TILL_EMPTY.
  - DECODE_ADDRESS otherwise, including data_in==3: stay.
  - WAIT_TILL_EMPTY: fifo_empty_[addr_q]=1 goes to LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA: always go to LOAD_DATA.
  - LOAD_DATA: fifo_full=1 goes to FIFO_FULL_STATE (wins over pkt_valid). Else pkt_valid=0 goes to LOAD_PARITY. Else stay.
  - FIFO_FULL_STATE: fifo_full=0 goes to LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done=1 goes to DECODE_ADDRESS. Else low_pkt_valid=1 goes to LOAD_PARITY. Else go to LOAD_DATA.
  - LOAD_PARITY: always go to CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full=1 goes to FIFO_FULL_STATE; else DECODE_ADDRESS.
- Soft reset: if soft_reset_[addr_q]=1 in any state other than DECODE_ADDRESS, next state is DECODE_ADDRESS.
  - Soft reset outranks every other transition.
  - Soft resets of non-selected FIFOs are ignored.
- Outputs are Moore, combinational decode of current state, no extra latency:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- Exactly one of detect_add, lfd_state, ld_state, laf_state, full_state is high, or none of them (LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY).
- Packet of N payload bytes with no full and target empty:
  - Cycle sequence: DECODE, LFD, LD × N, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE.
  - This is N+4 cycles header-to-idle.
- No latching of fifo_empty/fifo_full; these inputs are used as presented each cycle.

Test Plan:
1. Reset: resetn=0 mid-LOAD_DATA → outputs go immediately (asynchronously) to detect_add=1, busy=0, write_enb_reg=0; after release, state is DECODE_ADDRESS.
2. Normal packet: data_in=2'b01, fifo_empty_1=1, pkt_valid high for 1+3 cycles → state trace DECODE, LFD, LD, LD, LD, LP, CPE, DECODE. write_enb_reg high for 4 cycles, rst_int_reg high for 1 cycle.
3. Busy destination: data_in=2'b10, fifo_empty_2=0 for 5 cycles → WAIT_TILL_EMPTY with busy=1 for 5 cycles; LFD on the cycle after fifo_empty_2=1.
4. Full back-pressure: fifo_full=1 during LD for 3 cycles → full_state=1 for 3 cycles, then laf_state=1 for 1 cycle.
   - With parity_done=0, low_pkt_valid=0, returns to LD.
   - Repeat with low_pkt_valid=1: goes to LP.
5. Soft reset: soft_reset_1=1 during LD with addr_q=1 → DECODE next cycle. soft_reset_0=1 with addr_q=1 → no effect.
6. Invalid address: data_in=2'b11, pkt_valid=1 → stays in DECODE, busy=0, lfd_state never asserts.
